// File: rtl/dense_l2_pkg.sv
// Shared widths, FSM state codes and saturation helper for the dense layer-2 engine.
// Defining DENSE_L2_ARGMAX_EN adds the argmax class outputs to dense_l2_engine.
package dense_l2_pkg;

    localparam int IN_DIM = 32;
    localparam int FRAC   = 16;
    localparam int WORD_W = 32;
    localparam int PROD_W = 48;
    localparam int SUM_W  = 53;
    localparam int ADDR_W = 8;
    localparam int IDX_W  = 7;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_MUL   = 3'd2;
    localparam state_t S_SUM   = 3'd3;
    localparam state_t S_OUT   = 3'd4;

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(64'sh0000_0000_7FFF_FFFF);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-64'sh0000_0000_8000_0000);

    // Clamp a wide signed accumulator into the 32-bit Q format.
    function automatic logic [WORD_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
        if (v > SAT_MAX)
            saturate = 32'h7FFF_FFFF;
        else if (v < SAT_MIN)
            saturate = 32'h8000_0000;
        else
            saturate = v[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/dense_l2_dot32.sv
// Registered 32-lane fixed-point dot product: products in stage 1, sum in stage 2,
// saturated output. Both stages advance only while en is high.
module dense_l2_dot32
    import dense_l2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WORD_W-1:0] w [IN_DIM-1:0],
    input  logic [WORD_W-1:0] x [IN_DIM-1:0],
    output logic [WORD_W-1:0] y
);

    logic signed [63:0]       mul_full  [IN_DIM-1:0];
    logic signed [PROD_W-1:0] prod_next [IN_DIM-1:0];
    logic signed [PROD_W-1:0] prod_q    [IN_DIM-1:0];
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  sum_q;

    // Arithmetic shift floors toward minus infinity, matching the reference model.
    always_comb begin
        for (int i = 0; i < IN_DIM; i++) begin
            mul_full[i]  = $signed({{WORD_W{w[i][WORD_W-1]}}, w[i]})
                         * $signed({{WORD_W{x[i][WORD_W-1]}}, x[i]});
            prod_next[i] = PROD_W'(mul_full[i] >>> FRAC);
        end
    end

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < IN_DIM; i++)
            sum_next = sum_next + SUM_W'(prod_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN_DIM; i++)
                prod_q[i] <= '0;
            sum_q <= '0;
        end else if (en) begin
            prod_q <= prod_next;
            sum_q  <= sum_next;
        end
    end

    assign y = saturate(sum_q);

endmodule

// File: rtl/dense_l2_engine.sv
// Dense layer-2 engine: walks OUT_DIM neurons, fetches weights, streams saturated results.
// Define DENSE_L2_ARGMAX_EN to add class_idx/class_valid (argmax over the pass).
module dense_l2_engine
    import dense_l2_pkg::*;
#(
    parameter int OUT_DIM  = 10,
    parameter int READ_LAT = 2
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] x_in [IN_DIM-1:0],
    output logic [ADDR_W-1:0] addr_base,
    input  logic [WORD_W-1:0] w_in [IN_DIM-1:0],
    output logic              busy,
    output logic [WORD_W-1:0] y_data,
    output logic [IDX_W-1:0]  y_idx,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              y_last,
    output logic              done
`ifdef DENSE_L2_ARGMAX_EN
    ,
    output logic [IDX_W-1:0]  class_idx,
    output logic              class_valid
`endif
);

    localparam logic [IDX_W-1:0] LAST_N    = IDX_W'(OUT_DIM - 1);
    localparam logic [3:0]       FETCH_END = 4'(READ_LAT - 1);

    state_t            state;
    logic [IDX_W-1:0]  n;
    logic [IDX_W-1:0]  n_next;
    logic [3:0]        fetch_cnt;
    logic [WORD_W-1:0] x_q [IN_DIM-1:0];
    logic              dot_en;
    logic              handshake;

    assign n_next    = n + 1'b1;
    assign dot_en    = (state == S_MUL) || (state == S_SUM);
    assign handshake = (state == S_OUT) && y_ready;

    dense_l2_dot32 u_dot (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dot_en),
        .w     (w_in),
        .x     (x_q),
        .y     (y_data)
    );

    // A start coinciding with done is dropped so the caller must see busy low first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            n         <= '0;
            fetch_cnt <= '0;
            addr_base <= '0;
            busy      <= 1'b0;
            y_idx     <= '0;
            y_valid   <= 1'b0;
            y_last    <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < IN_DIM; i++)
                x_q[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !done) begin
                        x_q       <= x_in;
                        n         <= '0;
                        addr_base <= '0;
                        fetch_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_cnt == FETCH_END)
                        state <= S_MUL;
                    else
                        fetch_cnt <= fetch_cnt + 1'b1;
                end
                S_MUL: state <= S_SUM;
                S_SUM: begin
                    y_valid <= 1'b1;
                    y_idx   <= n;
                    y_last  <= (n == LAST_N);
                    state   <= S_OUT;
                end
                S_OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        y_last  <= 1'b0;
                        if (n != LAST_N) begin
                            n         <= n_next;
                            addr_base <= {n_next, 1'b0};
                            fetch_cnt <= '0;
                            state     <= S_FETCH;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DENSE_L2_ARGMAX_EN
    logic signed [WORD_W-1:0] best_val;
    logic [IDX_W-1:0]         best_idx;
    logic                     take_new;

    // Strict greater-than keeps the lowest index on ties.
    assign take_new = (n == '0) || ($signed(y_data) > best_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_val    <= '0;
            best_idx    <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            if (handshake) begin
                if (take_new) begin
                    best_val <= $signed(y_data);
                    best_idx <= n;
                end
                if (n == LAST_N) begin
                    class_idx   <= take_new ? n : best_idx;
                    class_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dense_l2_engine.sv
// Directed bench for dense_l2_engine with a two-cycle weight memory model.
// Build with DENSE_L2_ARGMAX_EN defined to also exercise the argmax outputs.
`timescale 1ns/1ps
module tb_dense_l2_engine;
    import dense_l2_pkg::*;

    localparam int OUT_DIM  = 10;
    localparam int READ_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        y_ready = 1'b1;
    logic [31:0] x_in [IN_DIM-1:0];
    logic [31:0] w_in [IN_DIM-1:0];
    logic [7:0]  addr_base;
    logic        busy;
    logic [31:0] y_data;
    logic [6:0]  y_idx;
    logic        y_valid;
    logic        y_last;
    logic        done;
`ifdef DENSE_L2_ARGMAX_EN
    logic [6:0]  class_idx;
    logic        class_valid;
`endif

    int checks = 0;
    int errors = 0;
    int mode = 0;
    logic [7:0] a1 = '0;
    logic [7:0] a2 = '0;

    dense_l2_engine #(.OUT_DIM(OUT_DIM), .READ_LAT(READ_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .addr_base (addr_base),
        .w_in      (w_in),
        .busy      (busy),
        .y_data    (y_data),
        .y_idx     (y_idx),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_last    (y_last),
        .done      (done)
`ifdef DENSE_L2_ARGMAX_EN
        ,
        .class_idx   (class_idx),
        .class_valid (class_valid)
`endif
    );

    always #5 clk = ~clk;

    // Weight memory: data appears READ_LAT cycles after addr_base changes.
    always @(posedge clk) begin
        a1 <= addr_base;
        a2 <= a1;
    end

    function automatic logic [31:0] weight_of(input int m, input int n, input int i);
        case (m)
            2, 3:    return 32'h0002_0000;
            4:       return (n == 6 || n == 8) ? 32'h0001_0000 : 32'(n * 32'h0000_1000);
            5:       return 32'((i + n) << 16);
            6:       return 32'h0000_8000;
            default: return 32'h0001_0000;
        endcase
    endfunction

    function automatic logic [31:0] x_of(input int m, input int i);
        case (m)
            1:       return 32'hFFFF_0000;
            2:       return 32'h7FFF_0000;
            3:       return 32'h8001_0000;
            5:       return (i < 16) ? 32'h0001_0000 : 32'h0000_0000;
            6:       return 32'hFFFF_FFFF;
            default: return 32'h0001_0000;
        endcase
    endfunction

    function automatic logic [31:0] expected_y(input int m, input int n);
        case (m)
            1:       return 32'hFFE0_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return (n == 6 || n == 8) ? 32'h0020_0000 : 32'(n * 32'h0002_0000);
            5:       return 32'((120 + 16 * n) << 16);
            6:       return 32'hFFFF_FFE0;
            default: return 32'h0020_0000;
        endcase
    endfunction

    always @* begin
        for (int i = 0; i < IN_DIM; i++)
            w_in[i] = weight_of(mode, int'(a2 >> 1), i);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (mode %0d, t=%0t)", tag, got, exp, mode, $time);
        end
    endtask

    task automatic applyStimulus(input int m);
        mode = m;
        for (int i = 0; i < IN_DIM; i++)
            x_in[i] = x_of(m, i);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < IN_DIM; i++)
            x_in[i] = 32'h1234_5678;
    endtask

    task automatic runPass(input int stall_idx, input int count, input bit restart_probe);
        for (int n = 0; n < count; n++) begin
            int waited = 0;
            while (!y_valid && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!y_valid) begin
                checkOutput("valid_timeout", 32'(y_valid), 32'd1);
                return;
            end
            checkOutput("latency", 32'(waited), 32'(READ_LAT + 2));
            checkOutput("y_data", y_data, expected_y(mode, n));
            checkOutput("y_idx", 32'(y_idx), 32'(n));
            checkOutput("y_last", 32'(y_last), 32'(n == OUT_DIM - 1));
            checkOutput("addr_base", 32'(addr_base), 32'(2 * n));
            checkOutput("busy", 32'(busy), 32'd1);
            if (n == stall_idx) begin
                y_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_valid", 32'(y_valid), 32'd1);
                    checkOutput("stall_data", y_data, expected_y(mode, n));
                    checkOutput("stall_idx", 32'(y_idx), 32'(n));
                    checkOutput("stall_addr", 32'(addr_base), 32'(2 * n));
                end
                y_ready = 1'b1;
            end
            @(negedge clk);
            checkOutput("valid_drop", 32'(y_valid), 32'd0);
            if (n == OUT_DIM - 1) begin
                checkOutput("done_pulse", 32'(done), 32'd1);
                checkOutput("busy_low", 32'(busy), 32'd0);
`ifdef DENSE_L2_ARGMAX_EN
                if (mode == 4) begin
                    checkOutput("class_valid", 32'(class_valid), 32'd1);
                    checkOutput("class_idx", 32'(class_idx), 32'd6);
                end
`endif
                if (restart_probe)
                    start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                checkOutput("done_once", 32'(done), 32'd0);
                checkOutput("no_restart", 32'(busy), 32'd0);
`ifdef DENSE_L2_ARGMAX_EN
                checkOutput("class_valid_once", 32'(class_valid), 32'd0);
`endif
            end else begin
                checkOutput("done_early", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        bit seen_done;
        for (int i = 0; i < IN_DIM; i++)
            x_in[i] = '0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(y_valid), 32'd0);
        checkOutput("rst_data", y_data, 32'd0);
        checkOutput("rst_addr", 32'(addr_base), 32'd0);
        checkOutput("rst_idx", 32'(y_idx), 32'd0);
        checkOutput("rst_last", 32'(y_last), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
`ifdef DENSE_L2_ARGMAX_EN
        checkOutput("rst_class_idx", 32'(class_idx), 32'd0);
        checkOutput("rst_class_valid", 32'(class_valid), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0);
        runPass(-1, OUT_DIM, 1'b1);
        applyStimulus(1);
        runPass(3, OUT_DIM, 1'b0);
        applyStimulus(2);
        runPass(-1, OUT_DIM, 1'b0);
        applyStimulus(3);
        runPass(-1, OUT_DIM, 1'b0);
        applyStimulus(5);
        runPass(-1, OUT_DIM, 1'b0);
        applyStimulus(6);
        runPass(-1, OUT_DIM, 1'b0);

        // Abort during the fetch of neuron 4, then rerun from scratch.
        applyStimulus(0);
        runPass(-1, 4, 1'b0);
        checkOutput("abort_addr", 32'(addr_base), 32'd8);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(y_valid), 32'd0);
        checkOutput("abort_data", y_data, 32'd0);
        checkOutput("abort_addr0", 32'(addr_base), 32'd0);
        checkOutput("abort_idx", 32'(y_idx), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        checkOutput("abort_no_done", 32'(seen_done), 32'd0);
        applyStimulus(0);
        runPass(-1, OUT_DIM, 1'b0);

`ifdef DENSE_L2_ARGMAX_EN
        applyStimulus(4);
        runPass(-1, OUT_DIM, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dense_l2_engine.md
Name: dense_l2_engine

Overview:
Compute engine for dense layer 2, sitting directly downstream of the layer-2 weight memory.
- Drives that memory's `addr_base`.
- Consumes the 32 parallel 32-bit weight words it returns and dots them with a latched 32-element activation vector.
- Streams one saturated fixed-point result per output neuron to the next stage over a valid/ready handshake.

Parameters:
- IN_DIM, 32, activation vector length; equals the number of weight words per memory read. Fixed at 32.
- OUT_DIM, 10, number of output neurons; legal range 1..128.
- FRAC, 16, fractional bits of the signed Q(32-FRAC).FRAC format used for x, w and y.
- READ_LAT, 2, cycles from an `addr_base` change to valid weights at `w_in`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin a layer pass when idle
- x_in  in  32 x 32  activation vector, unpacked array [IN_DIM-1:0]; sampled on an accepted start
- addr_base  out  8  weight memory base address
- w_in  in  32 x 32  weight words from the weight memory, unpacked array [31:0]
- busy  out  1  high from accepted start until done
- y_data  out  32  neuron result, signed QFRAC
- y_idx  out  7  neuron index of y_data
- y_valid  out  1  result valid
- y_ready  in  1  downstream accept
- y_last  out  1  high with y_valid on neuron OUT_DIM-1
- done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal counters and x register 0. Reset is asynchronous, active-low; it may assert mid-pass, aborts the pass, and no partial done is produced.
- Neuron n's weights are at `addr_base = 2*n`, and `addr_base` is held for the whole neuron.
- FSM states:
  - IDLE: `start=1` latches x_in, sets n=0, sets busy, goes to FETCH. A start while busy is ignored.
  - FETCH: drives `addr_base = 2*n` and counts READ_LAT cycles, then goes to MUL.
  - MUL: registers the 32 products `p[i] = (w_in[i]*x[i]) >>> FRAC`. Multiply is 64-bit signed, the shift is arithmetic (floor), and each result is kept as 48-bit signed.
  - SUM: registers the 53-bit signed sum of the 32 products, then saturates it to 32 bits (>0x7FFFFFFF gives 0x7FFFFFFF, <0x80000000 gives 0x80000000) into y_data. Sets y_valid and y_idx=n, and sets y_last if n==OUT_DIM-1.
  - OUT: holds y_data, y_idx, y_valid and y_last stable until `y_ready=1`. On the handshake y_valid drops next cycle. If n<OUT_DIM-1 then n++ and go to FETCH; otherwise pulse done, drop busy and go to IDLE.
- Latency: entry to FETCH until y_valid is READ_LAT+2 cycles. Minimum per-neuron period is READ_LAT+3 cycles with y_ready tied high.
- If y_ready is already high when y_valid rises, the handshake completes in that same cycle.
- A start in the same cycle as done is ignored; busy must be observed low first.
- x is stable for the whole pass; changes on x_in after the accepted start have no effect.

Optional Feature:
- DENSE_L2_ARGMAX_EN defined:
  - Adds outputs `class_idx` (7 bits) and `class_valid` (1 bit).
  - Tracks the signed maximum y_data over the pass; on a tie the lowest index wins.
  - class_idx is updated with done; class_valid pulses with done.
  - Both outputs reset to 0.
- Not defined: the ports and tracking logic are absent.

Decomposition:
- Package `dense_l2_pkg`:
  - localparams IN_DIM, FRAC, WORD_W=32, PROD_W=48, SUM_W=53, ADDR_W=8, IDX_W=7.
  - FSM state enum.
  - Saturate function.
- One natural sub-module: `dense_l2_dot32`. It is the registered 32-way multiply plus adder tree with saturation, with a fixed 2-cycle latency and an enable input.

Test Plan:
- Weights all 0x00010000, x all 0x00010000, OUT_DIM=10, y_ready=1 → ten results of 0x00200000, y_idx 0..9, y_last only on idx 9, done 1 cycle after idx 9, addr_base sequence 0,2,...,18.
- x all 0xFFFF0000 (-1.0), weights all 0x00010000 → every y_data = 0xFFE00000.
- x all 0x7FFF0000, weights all 0x00020000 → y_data 0x7FFFFFFF. With x negated → 0x80000000.
- y_ready held low 5 cycles on neuron 3 → y_data, y_idx and y_valid stable for 5 cycles, no addr_base change, resumes on release.
- rst_n low during FETCH of neuron 4 → all outputs 0 immediately, no done. A new start then produces the full sequence from idx 0.
- DENSE_L2_ARGMAX_EN defined, weights = n*0x00001000 except neurons 6 and 8 equal and maximal → class_idx=6, class_valid pulses with done.
